// File: rtl/input_acc_pkg.sv
// Shared types for the input accumulator scheduler: FSM states and lane payload.
package input_acc_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic signed [DATA_W-1:0] acc_data_t;

endpackage

// File: rtl/input_acc_skew_gen.sv
// Diagonal dequeue pattern: lane i strobes for L_i cycles starting at drain cycle k=i.
module input_acc_skew_gen #(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 4,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len [NUM_LANES],
  output logic [NUM_LANES-1:0] rd_en,
  output logic                 last
);

  localparam int K_W = CNT_W + LANE_W + 1;

  logic             active;
  logic [K_W-1:0]   k;
  logic [K_W-1:0]   k_end;
  logic [K_W-1:0]   end_i;
  logic [CNT_W-1:0] len_q [NUM_LANES];

  // k_end is the last cycle any lane still strobes; empty lanes do not extend it
  always_comb begin
    k_end = '0;
    end_i = '0;
    rd_en = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      end_i = K_W'(i) + K_W'(len_q[i]) - K_W'(1);
      if (len_q[i] != '0 && end_i > k_end) k_end = end_i;
      rd_en[i] = active && (k >= K_W'(i)) && (k < K_W'(i) + K_W'(len_q[i]));
    end
    last = active && (k == k_end);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      k      <= '0;
      for (int i = 0; i < NUM_LANES; i++) len_q[i] <= '0;
    end else if (start) begin
      active <= 1'b1;
      k      <= '0;
      for (int i = 0; i < NUM_LANES; i++) len_q[i] <= len[i];
    end else if (active) begin
      if (last) active <= 1'b0;
      else      k      <= k + K_W'(1);
    end
  end

endmodule

// File: rtl/input_acc_sched.sv
// Arbitrates nn/host writes into per-lane accumulator queues, tracks fill, and drains skewed.
// state | meaning
// IDLE  | no queued data, waiting for a write or start
// LOAD  | at least one write accepted since the last drain
// DRAIN | skewed dequeue in progress; writes refused
module input_acc_sched
  import input_acc_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 4,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  logic [LANE_W-1:0]           host_lane,
  input  acc_data_t                   host_data,
  input  logic                        nn_valid,
  input  logic [LANE_W-1:0]           nn_lane,
  input  acc_data_t                   nn_data,
  input  logic                        start,
  output logic [NUM_LANES-1:0]        acc_wr_valid,
  output logic [NUM_LANES*DATA_W-1:0] acc_wr_data,
  output logic [NUM_LANES-1:0]        acc_rd_en,
  output logic                        busy,
  output logic                        done,
  output logic                        err_overflow
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count   [NUM_LANES];
  logic [CNT_W-1:0] len_nxt [NUM_LANES];
  logic             host_lane_ok, nn_lane_ok, host_full;
  logic             wr_en, ovf_set, start_ok, any_len, skew_last;
  logic [LANE_W-1:0] wr_lane;
  acc_data_t        wr_data;

  assign host_lane_ok = (32'(host_lane) < NUM_LANES);
  assign nn_lane_ok   = (32'(nn_lane) < NUM_LANES);
  assign host_full    = host_lane_ok && (count[host_lane] == CNT_W'(DEPTH));
  assign host_ready   = !nn_valid && (state != DRAIN) && !host_full;
  assign start_ok     = start && (state != DRAIN);
  assign busy         = (state != IDLE);

  // nn has no back-pressure, so anything it cannot place is dropped and flagged
  always_comb begin
    wr_en   = 1'b0;
    wr_lane = '0;
    wr_data = '0;
    ovf_set = 1'b0;
    if (nn_valid) begin
      if (state != DRAIN && nn_lane_ok && count[nn_lane] != CNT_W'(DEPTH)) begin
        wr_en   = 1'b1;
        wr_lane = nn_lane;
        wr_data = nn_data;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (host_valid && host_ready) begin
      if (host_lane_ok) begin
        wr_en   = 1'b1;
        wr_lane = host_lane;
        wr_data = host_data;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  // drain lengths include a write landing in the same cycle as start
  always_comb begin
    any_len = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      len_nxt[i] = count[i] + CNT_W'(wr_en && (wr_lane == LANE_W'(i)));
      if (len_nxt[i] != '0) any_len = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: begin
        if (start_ok)   state_nxt = any_len ? DRAIN : IDLE;
        else if (wr_en) state_nxt = LOAD;
      end
      DRAIN:   if (skew_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc_wr_valid <= '0;
      acc_wr_data  <= '0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) count[i] <= '0;
    end else begin
      state        <= state_nxt;
      done         <= (start_ok && !any_len) || (state == DRAIN && skew_last);
      err_overflow <= err_overflow | ovf_set;
      for (int i = 0; i < NUM_LANES; i++) begin
        acc_wr_valid[i] <= wr_en && (wr_lane == LANE_W'(i));
        if (wr_en && wr_lane == LANE_W'(i)) acc_wr_data[DATA_W*i +: DATA_W] <= wr_data;
        if (start_ok)                       count[i] <= '0;
        else if (wr_en && wr_lane == LANE_W'(i)) count[i] <= count[i] + CNT_W'(1);
      end
    end
  end

  input_acc_skew_gen #(
    .NUM_LANES(NUM_LANES),
    .DEPTH    (DEPTH),
    .LANE_W   (LANE_W),
    .CNT_W    (CNT_W)
  ) u_skew (
    .clk  (clk),
    .rst  (rst),
    .start(start_ok && any_len),
    .len  (len_nxt),
    .rd_en(acc_rd_en),
    .last (skew_last)
  );

endmodule

// File: tb/tb_input_acc_sched.sv
// Directed bench for input_acc_sched with NUM_LANES=2, DEPTH=4.
module tb_input_acc_sched;

  logic        clk = 1'b0;
  logic        rst, host_valid, host_ready, nn_valid, start;
  logic        host_lane, nn_lane;
  logic [15:0] host_data, nn_data;
  logic [1:0]  acc_wr_valid, acc_rd_en;
  logic [31:0] acc_wr_data;
  logic        busy, done, err_overflow;
  int          total = 0;
  int          bad   = 0;
  int          n0, n1, seen_done, seen_rd;

  input_acc_sched #(.NUM_LANES(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready), .host_lane(host_lane), .host_data(host_data),
    .nn_valid(nn_valid), .nn_lane(nn_lane), .nn_data(nn_data),
    .start(start),
    .acc_wr_valid(acc_wr_valid), .acc_wr_data(acc_wr_data), .acc_rd_en(acc_rd_en),
    .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic lane, input logic [15:0] d, input logic exp_rdy);
    host_valid = 1'b1; host_lane = lane; host_data = d;
    #1;
    chk("host_ready", host_ready, exp_rdy);
    tick();
    host_valid = 1'b0;
    if (exp_rdy) begin
      chk("wr_valid", acc_wr_valid, lane ? 2'b10 : 2'b01);
      chk("wr_data", acc_wr_data[lane*16 +: 16], d);
    end else begin
      chk("wr_valid_dropped", acc_wr_valid, 2'b00);
    end
  endtask

  initial begin
    rst = 1'b1; host_valid = 1'b0; host_lane = 1'b0; host_data = '0;
    nn_valid = 1'b0; nn_lane = 1'b0; nn_data = '0; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_wr_valid", acc_wr_valid, 2'b00);
    chk("rst_rd_en", acc_rd_en, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_overflow, 1'b0);
    chk("rst_host_ready", host_ready, 1'b1);

    // 1: 3 writes lane0, 2 writes lane1, then skewed drain
    host_wr(1'b0, 16'h0011, 1'b1);
    chk("t1_busy_load", busy, 1'b1);
    host_wr(1'b0, 16'h0022, 1'b1);
    host_wr(1'b1, 16'h8001, 1'b1);
    host_wr(1'b0, 16'h0033, 1'b1);
    host_wr(1'b1, 16'h0102, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_k0_rd", acc_rd_en, 2'b01);
    chk("t1_k0_busy", busy, 1'b1);
    chk("t1_k0_done", done, 1'b0);
    tick();
    chk("t1_k1_rd", acc_rd_en, 2'b11);
    tick();
    chk("t1_k2_rd", acc_rd_en, 2'b11);
    chk("t1_k2_done", done, 1'b0);
    tick();
    chk("t1_k3_rd", acc_rd_en, 2'b00);
    chk("t1_k3_done", done, 1'b1);
    chk("t1_k3_busy", busy, 1'b0);
    tick();
    chk("t1_done_pulse", done, 1'b0);

    // 2: nn beats host on the same lane
    nn_valid = 1'b1; nn_lane = 1'b0; nn_data = 16'h1234;
    host_valid = 1'b1; host_lane = 1'b0; host_data = 16'h5678;
    #1;
    chk("t2_host_ready", host_ready, 1'b0);
    tick();
    nn_valid = 1'b0; host_valid = 1'b0;
    chk("t2_wr_valid", acc_wr_valid, 2'b01);
    chk("t2_wr_data", acc_wr_data, 32'h0102_1234);

    // 3: fill lane1, fifth host write refused, then nn overflow
    host_wr(1'b1, 16'h0A01, 1'b1);
    host_wr(1'b1, 16'h0A02, 1'b1);
    host_wr(1'b1, 16'h0A03, 1'b1);
    host_wr(1'b1, 16'h0A04, 1'b1);
    host_wr(1'b1, 16'h0A05, 1'b0);
    chk("t3_err_host_full", err_overflow, 1'b0);
    chk("t3_data_hold", acc_wr_data[31:16], 16'h0A04);
    nn_valid = 1'b1; nn_lane = 1'b1; nn_data = 16'hBEEF;
    tick();
    nn_valid = 1'b0;
    chk("t3_err_nn", err_overflow, 1'b1);
    chk("t3_nn_no_strobe", acc_wr_valid, 2'b00);
    // drain L={1,4}
    start = 1'b1;
    tick();
    start = 1'b0;
    n0 = 0; n1 = 0; seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        seen_done = 1;
        break;
      end
      n0 += int'(acc_rd_en[0]);
      n1 += int'(acc_rd_en[1]);
      tick();
    end
    chk("t3_drain_done", seen_done, 1);
    chk("t3_lane0_strobes", n0, 1);
    chk("t3_lane1_strobes", n1, 4);
    chk("t3_err_sticky", err_overflow, 1'b1);

    // 4: start with empty lanes
    tick();
    start = 1'b1;
    #1;
    chk("t4_busy_pre", busy, 1'b0);
    tick();
    start = 1'b0;
    chk("t4_done", done, 1'b1);
    chk("t4_rd", acc_rd_en, 2'b00);
    chk("t4_busy", busy, 1'b0);
    tick();
    chk("t4_done_pulse", done, 1'b0);
    chk("t4_rd2", acc_rd_en, 2'b00);

    // 5: reset at drain k=1
    host_wr(1'b0, 16'h0101, 1'b1);
    host_wr(1'b0, 16'h0202, 1'b1);
    host_wr(1'b1, 16'h0303, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t5_k1_rd", acc_rd_en, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rd", acc_rd_en, 2'b00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_wr_valid", acc_wr_valid, 2'b00);
    chk("t5_wr_data", acc_wr_data, 32'h0);
    chk("t5_err", err_overflow, 1'b0);
    seen_done = 0; seen_rd = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen_done |= int'(done);
      seen_rd   |= int'(|acc_rd_en);
    end
    chk("t5_no_done", seen_done, 0);
    chk("t5_no_rd", seen_rd, 0);

    // 6: start coincides with a host write to lane0 (count 1)
    host_wr(1'b0, 16'h0001, 1'b1);
    start = 1'b1;
    host_valid = 1'b1; host_lane = 1'b0; host_data = 16'h7FFF;
    #1;
    chk("t6_host_ready", host_ready, 1'b1);
    tick();
    start = 1'b0; host_valid = 1'b0;
    chk("t6_k0_wr_valid", acc_wr_valid, 2'b01);
    chk("t6_k0_wr_data", acc_wr_data[15:0], 16'h7FFF);
    chk("t6_k0_rd", acc_rd_en, 2'b01);
    chk("t6_k0_busy", busy, 1'b1);
    tick();
    chk("t6_k1_rd", acc_rd_en, 2'b01);
    chk("t6_k1_wr_valid", acc_wr_valid, 2'b00);
    chk("t6_k1_done", done, 1'b0);
    tick();
    chk("t6_k2_rd", acc_rd_en, 2'b00);
    chk("t6_k2_done", done, 1'b1);
    chk("t6_k2_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
